// File: rtl/configuration.sv
// rtl/configuration.sv - system-wide configuration constants
package configuration;

    // Upper bound on WAIT cycles for a single ramio transaction before it is aborted.
    localparam int RAMIO_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/ramio_arbiter_pkg.sv
// rtl/ramio_arbiter_pkg.sv - shared types and request decode for the ramio arbiter
package ramio_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } arb_state_e;

    // Request fields exactly as they are forwarded to ramio.
    typedef struct packed {
        logic [2:0]  read_type;
        logic [1:0]  write_type;
        logic [31:0] address;
        logic [31:0] data_in;
    } ram_req_t;

    // A request must be exactly one of read or write; neither-or-both is rejected.
    function automatic logic is_invalid_req(input logic [2:0] read_type,
                                            input logic [1:0] write_type);
        return (read_type != 3'd0) == (write_type != 2'd0);
    endfunction

    // Only meaningful for requests that already passed is_invalid_req.
    function automatic logic is_read_req(input logic [2:0] read_type);
        return read_type != 3'd0;
    endfunction

endpackage

// File: rtl/ramio_arbiter.sv
// rtl/ramio_arbiter.sv - two-master round-robin arbiter in front of the ramio port
module ramio_arbiter
    import ramio_arbiter_pkg::*;
#(
    parameter int TimeoutCycles = configuration::RAMIO_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic [2:0]  m0_read_type,
    input  logic [1:0]  m0_write_type,
    input  logic [31:0] m0_address,
    input  logic [31:0] m0_data_in,
    output logic        m0_ack,
    output logic        m0_rsp_valid,
    output logic [31:0] m0_rsp_data,
    output logic        m0_rsp_error,

    input  logic        m1_req,
    input  logic [2:0]  m1_read_type,
    input  logic [1:0]  m1_write_type,
    input  logic [31:0] m1_address,
    input  logic [31:0] m1_data_in,
    output logic        m1_ack,
    output logic        m1_rsp_valid,
    output logic [31:0] m1_rsp_data,
    output logic        m1_rsp_error,

    output logic        ram_enable,
    output logic [2:0]  ram_read_type,
    output logic [1:0]  ram_write_type,
    output logic [31:0] ram_address,
    output logic [31:0] ram_data_in,
    input  logic [31:0] ram_data_out,
    input  logic        ram_data_out_ready,
    input  logic        ram_busy
);

    localparam int CntW = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    arb_state_e      state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            granted_q, granted_d;
    ram_req_t        req_q, req_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic [1:0]      ack_q, ack_d;

    ram_req_t m0_fields, m1_fields, pick_fields;
    logic     pick;
    logic     wait_done;

    assign m0_fields = {m0_read_type, m0_write_type, m0_address, m0_data_in};
    assign m1_fields = {m1_read_type, m1_write_type, m1_address, m1_data_in};

    // Round robin: on a tie the master that was not served last wins.
    assign pick        = (m0_req & m1_req) ? ~last_grant_q : m1_req;
    assign pick_fields = pick ? m1_fields : m0_fields;

    // Reads finish on data_out_ready; writes finish once ramio drops busy.
    assign wait_done = is_read_req(req_q.read_type) ? ram_data_out_ready : ~ram_busy;

    // State and datapath registers; reset abandons any transaction silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            granted_q    <= 1'b0;
            req_q        <= '0;
            cnt_q        <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            ack_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            granted_q    <= granted_d;
            req_q        <= req_d;
            cnt_q        <= cnt_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            ack_q        <= ack_d;
        end
    end

    // Next-state logic: arbitrate, issue, wait with watchdog, respond.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        granted_d    = granted_q;
        req_d        = req_q;
        cnt_d        = cnt_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        ack_d        = 2'b00;

        unique case (state_q)
            ST_IDLE: begin
                if (!ram_busy && (m0_req || m1_req)) begin
                    granted_d  = pick;
                    req_d      = pick_fields;
                    ack_d      = pick ? 2'b10 : 2'b01;
                    rsp_data_d = '0;
                    if (is_invalid_req(pick_fields.read_type, pick_fields.write_type)) begin
                        // Rejected without ever touching ramio.
                        rsp_err_d = 1'b1;
                        state_d   = ST_RESPOND;
                    end else begin
                        rsp_err_d = 1'b0;
                        state_d   = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion takes priority over a simultaneous timeout.
                if (wait_done) begin
                    rsp_err_d  = 1'b0;
                    rsp_data_d = is_read_req(req_q.read_type) ? ram_data_out : 32'd0;
                    state_d    = ST_RESPOND;
                end else if (cnt_q == CntLast) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                    state_d    = ST_RESPOND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESPOND: begin
                last_grant_d = granted_q;
                cnt_d        = '0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic drive_ram;
    logic rsp_fire;

    assign drive_ram = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign rsp_fire  = (state_q == ST_RESPOND);

    assign ram_enable     = (state_q == ST_ISSUE);
    assign ram_read_type  = drive_ram ? req_q.read_type  : 3'd0;
    assign ram_write_type = drive_ram ? req_q.write_type : 2'd0;
    assign ram_address    = drive_ram ? req_q.address    : 32'd0;
    assign ram_data_in    = drive_ram ? req_q.data_in    : 32'd0;

    assign m0_ack       = ack_q[0];
    assign m1_ack       = ack_q[1];
    assign m0_rsp_valid = rsp_fire & ~granted_q;
    assign m1_rsp_valid = rsp_fire & granted_q;
    assign m0_rsp_data  = m0_rsp_valid ? rsp_data_q : 32'd0;
    assign m1_rsp_data  = m1_rsp_valid ? rsp_data_q : 32'd0;
    assign m0_rsp_error = m0_rsp_valid & rsp_err_q;
    assign m1_rsp_error = m1_rsp_valid & rsp_err_q;

endmodule

// File: doc/ramio_arbiter.md
# ramio_arbiter

Two-requester arbiter that shares the single `ramio` port between the `core` (master 0) and a secondary bus master (master 1, e.g. a flash/UART DMA loader). It serializes requests with round-robin fairness, drives exactly one `ramio` transaction at a time and returns completion/read data to the granted master. A per-transaction watchdog turns a hung `ramio` into an error response.

## Interface
- `TimeoutCycles`, default 4096: maximum number of WAIT cycles before the transaction is aborted with an error; must be ≥ 2.
- `clk`  in  1: system clock, the same clock as `ramio`.
- `rst`  in  1: synchronous, active-high reset.
- `mN_req`  in  1  (N∈{0,1}): request valid; held high until `mN_ack`.
- `mN_read_type`  in  3: read kind, `ramio` encoding; 0 means not a read.
- `mN_write_type`  in  2: write kind, `ramio` encoding; 0 means not a write.
- `mN_address`  in  32: byte address.
- `mN_data_in`  in  32: write data.
- `mN_ack`  out  1: one-cycle pulse; request fields have been captured.
- `mN_rsp_valid`  out  1: one-cycle completion pulse.
- `mN_rsp_data`  out  32: read data; valid only with `mN_rsp_valid`; 0 for writes and errors.
- `mN_rsp_error`  out  1: qualifies `mN_rsp_valid`; marks an invalid request or a timeout.
- `ram_enable`  out  1: to `ramio.enable`.
- `ram_read_type`  out  3: to `ramio.read_type`.
- `ram_write_type`  out  2: to `ramio.write_type`.
- `ram_address`  out  32: to `ramio.address`.
- `ram_data_in`  out  32: to `ramio.data_in`.
- `ram_data_out`  in  32: from `ramio.data_out`.
- `ram_data_out_ready`  in  1: from `ramio.data_out_ready`.
- `ram_busy`  in  1: from `ramio.busy`.

## Operation
- **States:** IDLE, ISSUE, WAIT, RESPOND.
- **IDLE**
  - Arbitrates only when `ram_busy`=0 and at least one `mN_req`=1.
  - If both masters request, the master that was not granted last wins. `last_grant` resets to 1, so m0 wins the first tie.
  - On the winning cycle, all request fields are latched and `granted` is recorded.
- **Request classification**
  - Read: `read_type`≠0 and `write_type`=0.
  - Write: `write_type`≠0 and `read_type`=0.
  - Any other combination is invalid. An invalid request goes IDLE→RESPOND with error=1 and never touches `ramio`. `mN_ack` is still pulsed.
- **ISSUE:** `ram_enable`=1 for exactly one cycle, with the latched fields on the `ram_*` outputs. Next state is WAIT.
- **WAIT**
  - A read completes on the first cycle with `ram_data_out_ready`=1; `ram_data_out` is captured that cycle.
  - A write completes on the first WAIT cycle with `ram_busy`=0. Contract: `ramio` raises `busy` in the cycle after `enable`.
  - The timeout counter increments each WAIT cycle. When it reaches `TimeoutCycles`-1 without completion, the transaction is aborted to RESPOND with error=1 and data=0.
  - If completion and timeout occur in the same cycle, completion wins.
- **RESPOND**
  - Pulses `mN_rsp_valid` for the granted master only, with data/error.
  - Sets `last_grant` to the granted master, clears the counter and returns to IDLE.
- **Side effects:** the non-granted master's `req` stays pending and is untouched. Requests are sampled only in IDLE.
- **Requester rule:** a master must deassert `req`, or present a new request, in the cycle after `ack`. `req` seen during ISSUE, WAIT or RESPOND is ignored.
- **Output hold:** `ram_read_type`, `ram_write_type`, `ram_address` and `ram_data_in` hold their latched values through WAIT. They are 0 in IDLE.

## Timing
- **Reset values:** all outputs 0, state IDLE, `last_grant`=1, counter 0.
- **Reset mid-transaction:** same as above, effective in the next cycle. No response is issued. `ramio` shares `rst` and is reset in the same cycle.
- **Request at cycle T** (IDLE, `ram_busy`=0):
  - T+1: `mN_ack`=1, `ram_enable`=1 (ISSUE).
  - T+2: first WAIT cycle.
  - `rsp_valid` occurs in the cycle after completion is detected.
- **Minimum latency:** write with `ram_busy` already low at T+2 gives `rsp_valid` at T+3, i.e. 3 cycles req→rsp.
- **Invalid request:** `ack` and error `rsp_valid` both occur at T+1.
- **Throughput:** the next grant can happen in the cycle after RESPOND. The maximum issue rate is one transaction per 4 cycles.
- **Worst case:** a timed-out transaction spends `TimeoutCycles` cycles in WAIT before RESPOND.

## Structure
- The state enum typedef and the invalid-request decode function go in the shared package `ramio_arbiter_pkg`.
- The `TimeoutCycles` default comes from `configuration::RAMIO_TIMEOUT_CYCLES`.
- Counter width is `$clog2(TimeoutCycles)`.
- Single module, no sub-module. The round-robin pick is a two-line expression; the watchdog is one counter.

## Test plan
- **Single write:** m0 writes `write_type`=3, addr 0x100, data 0xDEADBEEF; `ram_busy` is high for 5 cycles → `m0_ack` at T+1, one `ram_enable` pulse, `m0_rsp_valid` with error=0, data=0, after busy falls.
- **Single read:** m1 reads addr 0x100; `ram_data_out`=0xDEADBEEF with `ram_data_out_ready` at T+4 → `m1_rsp_data`=0xDEADBEEF at T+5, error=0.
- **Contention:** both masters request continuously for 4 transactions → grants alternate m0, m1, m0, m1, and no request is starved.
- **Invalid request:** m0 with `read_type`=2 and `write_type`=1 → `m0_ack` and `m0_rsp_valid` with error=1 at T+1, `ram_enable` never asserted.
- **Timeout:** `TimeoutCycles`=8, `ram_busy` stuck high → error response 8 cycles after entering WAIT, data=0. A second case asserts `ram_data_out_ready` on the timeout cycle → normal completion, error=0.
- **Reset in WAIT:** `rst` asserted mid-transaction → all outputs 0 the next cycle, no `rsp_valid`. After reset, simultaneous requests grant m0 first.
